// File: rtl/main_decoder_if.sv
// Decode-stage control bus: instruction fields in, registered control word out.
interface main_decoder_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       memtoreg;
  logic       memwrite;
  logic       branch;
  logic       bne;
  logic       alusrc;
  logic [1:0] regdst;
  logic       regwrite;
  logic       jump;
  logic       jal;
  logic       jr;
  logic       lb;
  logic       sb;
  logic       multordiv;
  logic       hlwrite;
  logic [1:0] mvhl;
  logic [1:0] aluop;

  // Pipeline side that supplies the instruction and consumes control
  modport master (
    output op, funct,
    input  memtoreg, memwrite, branch, bne, alusrc, regdst, regwrite,
           jump, jal, jr, lb, sb, multordiv, hlwrite, mvhl, aluop
  );

  // Decoder side
  modport slave (
    input  op, funct,
    output memtoreg, memwrite, branch, bne, alusrc, regdst, regwrite,
           jump, jal, jr, lb, sb, multordiv, hlwrite, mvhl, aluop
  );
endinterface

// File: rtl/main_decoder.sv
// Main control decoder for the pipelined MIPS core. Decodes op/funct into a
// 19-bit control word and registers it (one cycle latency, sync reset).
module main_decoder (
  input  logic              clk,
  input  logic              reset_n,
  main_decoder_if.slave     bus
);

  // Word layout, MSB to LSB:
  // {regwrite, regdst[1:0], alusrc, branch, bne, memwrite, memtoreg,
  //  jump, jal, jr, lb, sb, multordiv, hlwrite, mvhl[1:0], aluop[1:0]}
  localparam logic [18:0] W_RTYPE = 19'b1_01_0_0_0_0_0_0_0_0_0_0_0_0_00_10;
  localparam logic [18:0] W_JR    = 19'b0_00_0_0_0_0_0_0_0_1_0_0_0_0_00_10;
  localparam logic [18:0] W_MDIV  = 19'b0_00_0_0_0_0_0_0_0_0_0_0_1_1_00_10;
  localparam logic [18:0] W_MFHI  = 19'b1_01_0_0_0_0_0_0_0_0_0_0_0_0_10_10;
  localparam logic [18:0] W_MFLO  = 19'b1_01_0_0_0_0_0_0_0_0_0_0_0_0_01_10;
  localparam logic [18:0] W_LW    = 19'b1_00_1_0_0_0_1_0_0_0_0_0_0_0_00_00;
  localparam logic [18:0] W_LB    = 19'b1_00_1_0_0_0_1_0_0_0_1_0_0_0_00_00;
  localparam logic [18:0] W_SW    = 19'b0_00_1_0_0_1_0_0_0_0_0_0_0_0_00_00;
  localparam logic [18:0] W_SB    = 19'b0_00_1_0_0_1_0_0_0_0_0_1_0_0_00_00;
  localparam logic [18:0] W_BEQ   = 19'b0_00_0_1_0_0_0_0_0_0_0_0_0_0_00_01;
  localparam logic [18:0] W_BNE   = 19'b0_00_0_0_1_0_0_0_0_0_0_0_0_0_00_01;
  localparam logic [18:0] W_ADDI  = 19'b1_00_1_0_0_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [18:0] W_SLTI  = 19'b1_00_1_0_0_0_0_0_0_0_0_0_0_0_00_11;
  localparam logic [18:0] W_J     = 19'b0_00_0_0_0_0_0_1_0_0_0_0_0_0_00_00;
  localparam logic [18:0] W_JAL   = 19'b1_10_0_0_0_0_0_1_1_0_0_0_0_0_00_00;

  logic [18:0] ctrl_d;
  logic [18:0] ctrl_q;

  // Opcode/funct decode; unknown or X/Z encodings fall to the all-zero NOP word
  always_comb begin
    ctrl_d = '0;
    case (bus.op)
      6'b000000: begin
        case (bus.funct)
          6'b001000:                                  ctrl_d = W_JR;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: ctrl_d = W_MDIV;
          6'b010000:                                  ctrl_d = W_MFHI;
          6'b010010:                                  ctrl_d = W_MFLO;
          default:                                    ctrl_d = W_RTYPE;
        endcase
      end
      6'b100011: ctrl_d = W_LW;
      6'b100000: ctrl_d = W_LB;
      6'b101011: ctrl_d = W_SW;
      6'b101000: ctrl_d = W_SB;
      6'b000100: ctrl_d = W_BEQ;
      6'b000101: ctrl_d = W_BNE;
      6'b001000: ctrl_d = W_ADDI;
      6'b001010: ctrl_d = W_SLTI;
      6'b000010: ctrl_d = W_J;
      6'b000011: ctrl_d = W_JAL;
      default:   ctrl_d = '0;
    endcase
  end

  // Output register bank; reset forces the NOP word and drops any pending decode
  always_ff @(posedge clk) begin
    if (!reset_n) ctrl_q <= '0;
    else          ctrl_q <= ctrl_d;
  end

  assign {bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.bne,
          bus.memwrite, bus.memtoreg, bus.jump, bus.jal, bus.jr, bus.lb,
          bus.sb, bus.multordiv, bus.hlwrite, bus.mvhl, bus.aluop} = ctrl_q;

endmodule

// File: tb/tb_main_decoder.sv
// Directed-vector bench for main_decoder: each task applies op/funct, clocks,
// and compares the registered control word against hand-computed values.
module tb_main_decoder;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  main_decoder_if bus ();

  main_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] word;
  assign word = {bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.bne,
                 bus.memwrite, bus.memtoreg, bus.jump, bus.jal, bus.jr, bus.lb,
                 bus.sb, bus.multordiv, bus.hlwrite, bus.mvhl, bus.aluop};

  localparam logic [18:0] E_LW = 19'b1001000100000000000;

  // Reset held two cycles with lw on the bus, then released
  task automatic test_reset();
    reset_n = 1'b0;
    bus.op = 6'b100011;
    bus.funct = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (word !== 19'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: got %b expected %b", i, word, 19'b0);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (word !== E_LW) begin
      errors++;
      $display("FAIL reset_release_lw: got %b expected %b", word, E_LW);
    end
  endtask

  // R-type family: plain ALU, jr, mult/div group, mfhi, mflo
  task automatic test_rtype();
    logic [5:0]  fn  [9];
    logic [18:0] exp [9];
    fn[0] = 6'b100000; exp[0] = 19'b1010000000000000010;
    fn[1] = 6'b001000; exp[1] = 19'b0000000000100000010;
    fn[2] = 6'b011000; exp[2] = 19'b0000000000000110010;
    fn[3] = 6'b011001; exp[3] = 19'b0000000000000110010;
    fn[4] = 6'b011010; exp[4] = 19'b0000000000000110010;
    fn[5] = 6'b011011; exp[5] = 19'b0000000000000110010;
    fn[6] = 6'b010000; exp[6] = 19'b1010000000000001010;
    fn[7] = 6'b010010; exp[7] = 19'b1010000000000000110;
    fn[8] = 6'b101010; exp[8] = 19'b1010000000000000010;
    bus.op = 6'b000000;
    for (int i = 0; i < 9; i++) begin
      bus.funct = fn[i];
      @(posedge clk); #1;
      checks++;
      if (word !== exp[i]) begin
        errors++;
        $display("FAIL rtype_funct_%b: got %b expected %b", fn[i], word, exp[i]);
      end
    end
  endtask

  // All non-R opcodes plus an illegal one; funct set to a jr-looking value
  // to confirm it is ignored when op is non-zero
  task automatic test_opcodes();
    logic [5:0]  o   [13];
    logic [18:0] exp [13];
    o[0]  = 6'b100011; exp[0]  = 19'b1001000100000000000;
    o[1]  = 6'b101011; exp[1]  = 19'b0001001000000000000;
    o[2]  = 6'b100000; exp[2]  = 19'b1001000100010000000;
    o[3]  = 6'b101000; exp[3]  = 19'b0001001000001000000;
    o[4]  = 6'b000100; exp[4]  = 19'b0000100000000000001;
    o[5]  = 6'b000101; exp[5]  = 19'b0000010000000000001;
    o[6]  = 6'b000010; exp[6]  = 19'b0000000010000000000;
    o[7]  = 6'b000011; exp[7]  = 19'b1100000011000000000;
    o[8]  = 6'b001000; exp[8]  = 19'b1001000000000000000;
    o[9]  = 6'b001010; exp[9]  = 19'b1001000000000000011;
    o[10] = 6'b111111; exp[10] = 19'b0;
    o[11] = 6'b001001; exp[11] = 19'b0;
    o[12] = 6'b100100; exp[12] = 19'b0;
    for (int i = 0; i < 13; i++) begin
      bus.op = o[i];
      bus.funct = (i % 2 == 0) ? 6'b001000 : 6'b011000;
      @(posedge clk); #1;
      checks++;
      if (word !== exp[i]) begin
        errors++;
        $display("FAIL opcode_%b: got %b expected %b", o[i], word, exp[i]);
      end
    end
  endtask

  // New op changes every cycle; before the edge the old word must still hold
  task automatic test_back_to_back();
    logic [5:0]  o   [4];
    logic [18:0] exp [4];
    logic [18:0] prev;
    o[0] = 6'b000011; exp[0] = 19'b1100000011000000000;
    o[1] = 6'b101011; exp[1] = 19'b0001001000000000000;
    o[2] = 6'b000100; exp[2] = 19'b0000100000000000001;
    o[3] = 6'b001010; exp[3] = 19'b1001000000000000011;
    bus.funct = 6'b000000;
    bus.op = 6'b111111;
    @(posedge clk); #1;
    prev = 19'b0;
    for (int i = 0; i < 4; i++) begin
      bus.op = o[i];
      #2;
      checks++;
      if (word !== prev) begin
        errors++;
        $display("FAIL b2b_hold_%0d: got %b expected %b", i, word, prev);
      end
      @(posedge clk); #1;
      checks++;
      if (word !== exp[i]) begin
        errors++;
        $display("FAIL b2b_word_%0d: got %b expected %b", i, word, exp[i]);
      end
      prev = exp[i];
    end
  endtask

  // Reset asserted while a decode is pending discards it
  task automatic test_reset_midstream();
    bus.op = 6'b001000;
    bus.funct = 6'b000000;
    @(posedge clk); #1;
    checks++;
    if (word !== 19'b1001000000000000000) begin
      errors++;
      $display("FAIL mid_pre_addi: got %b expected %b", word, 19'b1001000000000000000);
    end
    bus.op = 6'b000011;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (word !== 19'b0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %b expected %b", word, 19'b0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (word !== 19'b1100000011000000000) begin
      errors++;
      $display("FAIL mid_release_jal: got %b expected %b", word, 19'b1100000011000000000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.op = 6'b000000;
    bus.funct = 6'b000000;
    #1;
    test_reset();
    test_rtype();
    test_opcodes();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder for the pipelined MIPS core, located in the decode stage.
- Maps the instruction opcode and, for R-type instructions, the funct field to a 19-bit control word.
- The control word drives register-file write, destination select, ALU source and ALU-op class, branch/jump, memory access (word/byte), and the HI/LO multiply-divide path.
- Outputs are registered: one cycle of latency, with synchronous active-low reset.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  synchronous active-low reset
- op  input  6  instruction opcode [31:26]
- funct  input  6  instruction funct [5:0]; only used when op=000000
- memtoreg  output  1  writeback selects memory data
- memwrite  output  1  data-memory write
- branch  output  1  beq
- bne  output  1  bne
- alusrc  output  1  ALU B operand = sign-extended immediate
- regdst  output  2  destination register: 00=rt, 01=rd, 10=$ra(31), 11 unused
- regwrite  output  1  register-file write enable
- jump  output  1  j/jal target select
- jal  output  1  link: write PC+4 to $ra
- jr  output  1  jump-register
- lb  output  1  byte load
- sb  output  1  byte store
- multordiv  output  1  mult/div unit operation
- hlwrite  output  1  HI/LO register write
- mvhl  output  2  writeback from HI/LO: 00=none, 10=HI, 01=LO
- aluop  output  2  00=add, 01=sub, 10=use funct, 11=slt

Behaviour:
- Control word ordering, MSB to LSB, used by verification: {regwrite, regdst[1:0], alusrc, branch, bne, memwrite, memtoreg, jump, jal, jr, lb, sb, multordiv, hlwrite, mvhl[1:0], aluop[1:0]}.
- Combinational decode feeds one output register bank updated on rising clk.
  - Outputs reflect the op/funct sampled at the previous edge.
- Reset: when reset_n=0 at a rising edge, all outputs clear to 0 (the NOP word), overriding decode.
  - Reset asserted mid-stream discards the pending decode.
  - First decode appears at the edge after reset_n returns to 1.
- Decode table (any field not listed = 0):
  - op=000000 R-type, default funct: regwrite=1, regdst=01, aluop=10.
  - op=000000, funct=001000 (jr): jr=1, aluop=10, regwrite=0.
  - op=000000, funct=011000/011001/011010/011011 (mult/multu/div/divu): multordiv=1, hlwrite=1, aluop=10, regwrite=0.
  - op=000000, funct=010000 (mfhi): regwrite=1, regdst=01, mvhl=10, aluop=10.
  - op=000000, funct=010010 (mflo): regwrite=1, regdst=01, mvhl=01, aluop=10.
  - op=100011 lw: regwrite=1, regdst=00, alusrc=1, memtoreg=1, aluop=00.
  - op=100000 lb: as lw, plus lb=1.
  - op=101011 sw: alusrc=1, memwrite=1, aluop=00.
  - op=101000 sb: as sw, plus sb=1.
  - op=000100 beq: branch=1, aluop=01.
  - op=000101 bne: bne=1, aluop=01.
  - op=001000 addi: regwrite=1, alusrc=1, aluop=00.
  - op=001010 slti: regwrite=1, alusrc=1, aluop=11.
  - op=000010 j: jump=1.
  - op=000011 jal: jump=1, jal=1, regwrite=1, regdst=10.
  - Any other op: all outputs 0; no X ever driven.
- funct is ignored for every non-zero op.
- X/Z on op or funct must not propagate: a case default yields the all-zero word.

Test Plan:
- Reset: reset_n=0 for 2 cycles with op=100011 → word 0000000000000000000 after each edge; release → next edge gives the lw word 1001000100000000000.
- R-type add: op=000000, funct=100000 → 1010000000000000010; funct=001000 → 0000000000100000010 (jr).
- mult/mfhi/mflo: funct=011000 → 0000000000000110010.
  - funct=010000 → 1010000000000001010.
  - funct=010010 → 1010000000000000110.
- Memory: sw → 0001001000000000000; lb → 1001000100010000000; sb → 0001001000001000000.
- Control flow: beq → 0000100000000000001; bne → 0000010000000000001; j → 0000000010000000000; jal → 1100000011000000000.
- Immediates and illegal: addi → 1001000000000000000; slti → 1001000000000000011; op=111111 → all zeros. Each word appears exactly one cycle after op is applied.
